// File: rtl/sound_bridge_pkg.sv
// Shared constants for the Z80-side sound command bridge.
// Build option: LATCH_FIFO_EN swaps the single command latch for a small FIFO.
package sound_bridge_pkg;

  localparam int IRQ_DIV_DEFAULT = 3200;
  localparam int BANK_W_DEFAULT  = 5;

  // {M1_n, IORQ_n} level that marks a Z80 interrupt-acknowledge cycle.
  localparam logic [1:0] ACK_ACTIVE = 2'b00;

endpackage

// File: rtl/sound_latch_bridge_edge_rise.sv
// One-register rising-edge detector for a level strobe.
// During reset the register tracks the strobe, so a strobe held across reset release never fires.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    prev <= level;
  end

  assign rise = level & ~prev & ~reset;

endmodule

// File: rtl/sound_latch_bridge.sv
// Z80-side responder for the 68k-to-sound command path: command latch, NMI, bank, DAC and periodic IRQ.
// Build option: define LATCH_FIFO_EN to replace the single command latch with a FIFO_DEPTH-entry FIFO.
module sound_latch_bridge
  import sound_bridge_pkg::*;
#(
  parameter int IRQ_DIV    = IRQ_DIV_DEFAULT,
  parameter int BANK_W     = BANK_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m68k_latch_cs,
  input  logic [7:0]        m68k_din,
  input  logic              z80_latch_cs,
  input  logic              z80_latch_clr_cs,
  input  logic              z80_dac_cs,
  input  logic              z80_bank_set_cs,
  input  logic [7:0]        z80_din,
  input  logic              M1_n,
  input  logic              IORQ_n,
  output logic [7:0]        latch_dout,
  output logic              latch_pending,
  output logic              latch_overrun,
  output logic              z80_nmi_n,
  output logic              z80_irq_n,
  output logic [BANK_W-1:0] bank,
  output logic [7:0]        dac_out
);

  localparam int CNT_W = $clog2(IRQ_DIV);

  logic ack;
  logic wr_rise, rd_rise, clr_rise, dac_rise, bank_rise, ack_rise;
  logic unused_rd;

  assign ack       = ({M1_n, IORQ_n} == ACK_ACTIVE);
  assign unused_rd = rd_rise;

  edge_rise u_wr   (.clk(clk), .reset(reset), .level(m68k_latch_cs),    .rise(wr_rise));
  edge_rise u_rd   (.clk(clk), .reset(reset), .level(z80_latch_cs),     .rise(rd_rise));
  edge_rise u_clr  (.clk(clk), .reset(reset), .level(z80_latch_clr_cs), .rise(clr_rise));
  edge_rise u_dac  (.clk(clk), .reset(reset), .level(z80_dac_cs),       .rise(dac_rise));
  edge_rise u_bank (.clk(clk), .reset(reset), .level(z80_bank_set_cs),  .rise(bank_rise));
  edge_rise u_ack  (.clk(clk), .reset(reset), .level(ack),              .rise(ack_rise));

`ifdef LATCH_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic           empty, full, push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop_ok  = clr_rise & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign push_ok = wr_rise & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      latch_overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= m68k_din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok) count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
      if (wr_rise && !push_ok) latch_overrun <= 1'b1;
    end
  end

  assign latch_dout    = empty ? 8'h00 : mem[rd_ptr];
  assign latch_pending = ~empty;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_dout    <= 8'h00;
      latch_pending <= 1'b0;
      latch_overrun <= 1'b0;
    end else if (wr_rise) begin
      // A write coinciding with a clear wins: the new command stays pending.
      latch_dout    <= m68k_din;
      latch_pending <= 1'b1;
      if (latch_pending) latch_overrun <= 1'b1;
    end else if (clr_rise) begin
      latch_pending <= 1'b0;
    end
  end
`endif

  logic [CNT_W-1:0] irq_cnt;
  logic             wrap;

  assign wrap = (irq_cnt == CNT_W'(IRQ_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_cnt   <= '0;
      z80_irq_n <= 1'b1;
      z80_nmi_n <= 1'b1;
      bank      <= '0;
      dac_out   <= 8'h00;
    end else begin
      irq_cnt   <= wrap ? '0 : irq_cnt + 1'b1;
      z80_nmi_n <= ~latch_pending;
      if (wrap) z80_irq_n <= 1'b0;
      else if (ack_rise) z80_irq_n <= 1'b1;
      if (bank_rise) bank <= z80_din[BANK_W-1:0];
      if (dac_rise) dac_out <= z80_din;
    end
  end

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Self-checking bench for sound_latch_bridge (IRQ_DIV=8); covers the FIFO build when LATCH_FIFO_EN is defined.
module tb_sound_latch_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       m68k_latch_cs, z80_latch_cs, z80_latch_clr_cs, z80_dac_cs, z80_bank_set_cs;
  logic [7:0] m68k_din, z80_din;
  logic       M1_n, IORQ_n;
  logic [7:0] latch_dout, dac_out;
  logic       latch_pending, latch_overrun, z80_nmi_n, z80_irq_n;
  logic [4:0] bank;

  sound_latch_bridge #(.IRQ_DIV(8), .BANK_W(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .m68k_latch_cs(m68k_latch_cs), .m68k_din(m68k_din),
    .z80_latch_cs(z80_latch_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
    .z80_dac_cs(z80_dac_cs), .z80_bank_set_cs(z80_bank_set_cs),
    .z80_din(z80_din), .M1_n(M1_n), .IORQ_n(IORQ_n),
    .latch_dout(latch_dout), .latch_pending(latch_pending), .latch_overrun(latch_overrun),
    .z80_nmi_n(z80_nmi_n), .z80_irq_n(z80_irq_n), .bank(bank), .dac_out(dac_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       is_dac;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives a bank or DAC write, changing the data after the first edge while the strobe is held.
  task automatic drive_reg(input logic is_dac, input logic [7:0] din, input logic [7:0] exp);
    z80_din = din;
    if (is_dac) z80_dac_cs = 1'b1;
    else z80_bank_set_cs = 1'b1;
    exp_q.push_back(exp);
    tick();
    z80_din = ~din;
    tick();
    tick();
    z80_dac_cs = 1'b0;
    z80_bank_set_cs = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    logic [7:0] e;
    logic exp_ovr;

    vecs[0] = '{1'b0, 8'hFF, 8'h1F};
    vecs[1] = '{1'b0, 8'h0A, 8'h0A};
    vecs[2] = '{1'b1, 8'h80, 8'h80};
    vecs[3] = '{1'b1, 8'h3C, 8'h3C};
    vecs[4] = '{1'b0, 8'hE3, 8'h03};

    reset = 1'b1;
    m68k_latch_cs = 0; z80_latch_cs = 0; z80_latch_clr_cs = 0;
    z80_dac_cs = 0; z80_bank_set_cs = 0;
    m68k_din = 0; z80_din = 0; M1_n = 1; IORQ_n = 1;
    repeat (3) tick();
    check("reset dout", 16'(latch_dout), 16'h00);
    check("reset pending", 16'(latch_pending), 16'h0);
    check("reset overrun", 16'(latch_overrun), 16'h0);
    check("reset nmi_n", 16'(z80_nmi_n), 16'h1);
    check("reset irq_n", 16'(z80_irq_n), 16'h1);
    check("reset bank", 16'(bank), 16'h0);
    check("reset dac", 16'(dac_out), 16'h0);
    reset = 1'b0;
    tick();

`ifdef LATCH_FIFO_EN
    exp_ovr = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      m68k_din = 8'(v);
      m68k_latch_cs = 1'b1;
      if (exp_q.size() < 4) exp_q.push_back(8'(v));
      else exp_ovr = 1'b1;
      tick();
      tick();
      m68k_latch_cs = 1'b0;
      tick();
    end
    check("fifo overrun", 16'(latch_overrun), 16'(exp_ovr));
    check("fifo pending full", 16'(latch_pending), 16'h1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fifo head", 16'(latch_dout), 16'(e));
      z80_latch_clr_cs = 1'b1;
      tick();
      tick();
      z80_latch_clr_cs = 1'b0;
      tick();
    end
    check("fifo empty pending", 16'(latch_pending), 16'h0);
    check("fifo empty dout", 16'(latch_dout), 16'h00);
    z80_latch_clr_cs = 1'b1;
    tick();
    z80_latch_clr_cs = 1'b0;
    tick();
    check("fifo pop empty", 16'(latch_pending), 16'h0);
    check("fifo nmi idle", 16'(z80_nmi_n), 16'h1);
`else
    m68k_din = 8'h5A;
    m68k_latch_cs = 1'b1;
    tick();
    check("write dout", 16'(latch_dout), 16'h5A);
    check("write pending", 16'(latch_pending), 16'h1);
    check("nmi latency", 16'(z80_nmi_n), 16'h1);
    m68k_din = 8'h33;
    tick();
    check("nmi asserted", 16'(z80_nmi_n), 16'h0);
    repeat (4) tick();
    check("held write once", 16'(latch_dout), 16'h5A);
    check("no overrun", 16'(latch_overrun), 16'h0);
    m68k_latch_cs = 1'b0;
    tick();

    m68k_din = 8'hA5;
    m68k_latch_cs = 1'b1;
    tick();
    m68k_latch_cs = 1'b0;
    check("overwrite dout", 16'(latch_dout), 16'hA5);
    check("overrun set", 16'(latch_overrun), 16'h1);
    tick();

    z80_latch_clr_cs = 1'b1;
    tick();
    z80_latch_clr_cs = 1'b0;
    check("clear pending", 16'(latch_pending), 16'h0);
    check("clear nmi latency", 16'(z80_nmi_n), 16'h0);
    tick();
    check("clear nmi_n", 16'(z80_nmi_n), 16'h1);
    check("clear keeps dout", 16'(latch_dout), 16'hA5);

    m68k_din = 8'h11;
    m68k_latch_cs = 1'b1;
    z80_latch_clr_cs = 1'b1;
    tick();
    m68k_latch_cs = 1'b0;
    z80_latch_clr_cs = 1'b0;
    check("write beats clear pending", 16'(latch_pending), 16'h1);
    check("write beats clear dout", 16'(latch_dout), 16'h11);
    tick();

    z80_latch_cs = 1'b1;
    repeat (2) tick();
    z80_latch_cs = 1'b0;
    tick();
    check("read no side effect dout", 16'(latch_dout), 16'h11);
    check("read no side effect pend", 16'(latch_pending), 16'h1);
`endif

    for (int i = 0; i < 5; i++) begin
      drive_reg(vecs[i].is_dac, vecs[i].din, vecs[i].exp);
      e = exp_q.pop_front();
      if (vecs[i].is_dac) check("dac write", 16'(dac_out), 16'(e));
      else check("bank write", 16'(bank), 16'(e));
    end

    reset = 1'b1;
    z80_din = 8'h55; m68k_din = 8'h77;
    z80_dac_cs = 1'b1; z80_bank_set_cs = 1'b1; m68k_latch_cs = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("reset strobe dac", 16'(dac_out), 16'h00);
    check("reset strobe bank", 16'(bank), 16'h00);
    check("reset strobe pending", 16'(latch_pending), 16'h0);
    check("reset strobe dout", 16'(latch_dout), 16'h00);
    z80_dac_cs = 1'b0; z80_bank_set_cs = 1'b0; m68k_latch_cs = 1'b0;
    tick();

    n = 0;
    while (z80_irq_n && n < 40) begin
      tick();
      n++;
    end
    check("irq first fall", 16'(z80_irq_n), 16'h0);

    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
    check("ack clears irq", 16'(z80_irq_n), 16'h1);
    repeat (2) tick();
    M1_n = 1'b1; IORQ_n = 1'b1;
    n = 3;
    while (z80_irq_n && n < 20) begin
      tick();
      n++;
    end
    check("irq period", 16'(n), 16'd8);

    repeat (7) tick();
    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
    check("ack at wrap", 16'(z80_irq_n), 16'h0);
    repeat (2) tick();
    check("held ack once", 16'(z80_irq_n), 16'h0);
    M1_n = 1'b1; IORQ_n = 1'b1;
    tick();
    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
    check("later ack clears", 16'(z80_irq_n), 16'h1);
    M1_n = 1'b1; IORQ_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
